operand_issue_ctrl: RTL and testbench

Operand-fetch sequencer in the decode stage. It accepts one instruction at a time, reads its rs1 and rs2 values through the single shared register-file read port, and drives R, Imm and IS for the second-operand handler `source_operand`. It then presents the finished operand bundle downstream with a valid/ready handshake. It holds the only arbitration point for the register-file read port during decode.

---
 rtl/operand_issue_ctrl_if.sv | 29 ++
 rtl/operand_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_operand_issue_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_issue_ctrl_if.sv
// Decode-stage operand fetch bundle: upstream instruction handshake, shared register-file
// read port, operand outputs for source_operand, and downstream handshake.
interface operand_issue_ctrl_if;
  logic        flush;
  logic [31:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic        rf_rd_en;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] rs1_val;
  logic [31:0] R;
  logic [21:0] Imm;
  logic [3:0]  IS;
  logic [4:0]  rd;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  state_dbg;

  modport master (
    input  flush, instr, in_valid, rf_data, out_ready,
    output in_ready, rf_rd_en, rf_addr, rs1_val, R, Imm, IS, rd, out_valid, state_dbg
  );

  modport slave (
    output flush, instr, in_valid, rf_data, out_ready,
    input  in_ready, rf_rd_en, rf_addr, rs1_val, R, Imm, IS, rd, out_valid, state_dbg
  );
endinterface

// File: rtl/operand_issue_ctrl.sv
// Operand-fetch sequencer: accepts one instruction, reads rs1/rs2 through the single
// register-file read port, decodes IS/Imm, and presents the operand bundle downstream.
module operand_issue_ctrl (
  input  logic                clk,
  input  logic                reset,
  operand_issue_ctrl_if.master bus
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE without flush; out_valid is high only in DONE, and the
  // bundle is held stable until out_ready is seen (a same-cycle flush cancels the transfer).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RS1  = 2'd1,
    S_RS2  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  rs1_addr_q, rs1_addr_d;
  logic [4:0]  rs2_addr_q, rs2_addr_d;
  logic        need_rs2_q, need_rs2_d;
  logic [31:0] rs1_val_q, rs1_val_d;
  logic [31:0] r_q, r_d;
  logic [21:0] imm_q, imm_d;
  logic [3:0]  is_q, is_d;
  logic [4:0]  rd_q, rd_d;

  logic        in_ready_c;
  logic        rf_rd_en_c;
  logic [4:0]  rf_addr_c;
  logic        out_valid_c;

  logic        dec_fmt3;
  logic        dec_shift;
  logic [21:0] dec_imm;
  logic [3:0]  dec_is;

  always_comb begin
    dec_fmt3  = bus.instr[31];
    dec_shift = (bus.instr[24:19] == 6'b100101) || (bus.instr[24:19] == 6'b100110) ||
                (bus.instr[24:19] == 6'b100111);
    dec_imm   = '0;
    dec_is    = 4'b0000;
    case (bus.instr[31:30])
      2'b00: begin
        dec_imm = bus.instr[21:0];
        dec_is  = (bus.instr[24:22] == 3'b100) ? 4'b0000 : 4'b0010;
      end
      2'b01: begin
        dec_imm = '0;
        dec_is  = 4'b0000;
      end
      default: begin
        if (dec_shift) begin
          dec_is  = bus.instr[13] ? 4'b1100 : 4'b1110;
          dec_imm = bus.instr[13] ? {17'b0, bus.instr[4:0]} : 22'b0;
        end else begin
          dec_is  = bus.instr[13] ? 4'b1010 : 4'b1000;
          dec_imm = bus.instr[13] ? {9'b0, bus.instr[12:0]} : 22'b0;
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    need_rs2_d  = need_rs2_q;
    rs1_val_d   = rs1_val_q;
    r_d         = r_q;
    imm_d       = imm_q;
    is_d        = is_q;
    rd_d        = rd_q;
    in_ready_c  = 1'b0;
    rf_rd_en_c  = 1'b0;
    rf_addr_c   = '0;
    out_valid_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_c = !bus.flush;
        if (bus.in_valid && !bus.flush) begin
          rs1_addr_d = bus.instr[18:14];
          rs2_addr_d = bus.instr[4:0];
          rd_d       = bus.instr[29:25];
          imm_d      = dec_imm;
          is_d       = dec_is;
          rs1_val_d  = '0;
          r_d        = '0;
          need_rs2_d = dec_fmt3 && !bus.instr[13];
          state_d    = dec_fmt3 ? S_RS1 : S_DONE;
        end
      end
      S_RS1: begin
        rf_addr_c  = rs1_addr_q;
        rf_rd_en_c = (rs1_addr_q != 5'd0);
        if (!bus.flush) rs1_val_d = rf_rd_en_c ? bus.rf_data : 32'd0;
        state_d    = need_rs2_q ? S_RS2 : S_DONE;
      end
      S_RS2: begin
        rf_addr_c  = rs2_addr_q;
        rf_rd_en_c = (rs2_addr_q != 5'd0);
        if (!bus.flush) r_d = rf_rd_en_c ? bus.rf_data : 32'd0;
        state_d    = S_DONE;
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush discards whatever is in flight; any partially captured operands are dead.
    if (bus.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      need_rs2_q <= 1'b0;
      rs1_val_q  <= '0;
      r_q        <= '0;
      imm_q      <= '0;
      is_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      need_rs2_q <= need_rs2_d;
      rs1_val_q  <= rs1_val_d;
      r_q        <= r_d;
      imm_q      <= imm_d;
      is_q       <= is_d;
      rd_q       <= rd_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.rf_rd_en  = rf_rd_en_c;
  assign bus.rf_addr   = rf_addr_c;
  assign bus.out_valid = out_valid_c;
  assign bus.rs1_val   = rs1_val_q;
  assign bus.R         = r_q;
  assign bus.Imm       = imm_q;
  assign bus.IS        = is_q;
  assign bus.rd        = rd_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_operand_issue_ctrl.sv
// Bench for operand_issue_ctrl: transaction-level model with per-cycle compare plus
// directed instructions with hand-computed operand bundles and latencies.
module tb_operand_issue_ctrl;

  logic clk = 1'b0;
  logic reset;
  operand_issue_ctrl_if bus ();

  operand_issue_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] rf_mem [32];
  assign bus.rf_data = rf_mem[bus.rf_addr];

  int n_pass   = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_READ, M_DONE} mode_t;
  mode_t       m_mode = M_IDLE;
  logic [4:0]  rd_sched[$];
  logic [94:0] exp_q[$];   // {rd, IS, Imm, rs1_val, R}

  function automatic logic [31:0] reg_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf_mem[a];
  endfunction

  function automatic logic [94:0] model_bundle(input logic [31:0] ins);
    logic [3:0]  is_v;
    logic [21:0] imm_v;
    logic [31:0] rs1_v;
    logic [31:0] r_v;
    logic [5:0]  op3;
    is_v = 4'd0; imm_v = 22'd0; rs1_v = 32'd0; r_v = 32'd0;
    op3  = ins[24:19];
    if (ins[31:30] == 2'b00) begin
      imm_v = ins[21:0];
      is_v  = (ins[24:22] == 3'b100) ? 4'b0000 : 4'b0010;
    end else if (ins[31:30] == 2'b10 || ins[31:30] == 2'b11) begin
      rs1_v = reg_val(ins[18:14]);
      r_v   = ins[13] ? 32'd0 : reg_val(ins[4:0]);
      if (op3 == 6'h25 || op3 == 6'h26 || op3 == 6'h27) begin
        is_v  = ins[13] ? 4'b1100 : 4'b1110;
        imm_v = ins[13] ? 22'(ins[4:0]) : 22'd0;
      end else begin
        is_v  = ins[13] ? 4'b1010 : 4'b1000;
        imm_v = ins[13] ? 22'(ins[12:0]) : 22'd0;
      end
    end
    return {ins[29:25], is_v, imm_v, rs1_v, r_v};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE;
      rd_sched.delete();
      exp_q.delete();
    end else if (bus.flush) begin
      if (m_mode != M_IDLE) void'(exp_q.pop_back());
      rd_sched.delete();
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (bus.in_valid) begin
          exp_q.push_back(model_bundle(bus.instr));
          if (bus.instr[31]) begin
            rd_sched.push_back(bus.instr[18:14]);
            if (!bus.instr[13]) rd_sched.push_back(bus.instr[4:0]);
          end
          m_mode = (rd_sched.size() != 0) ? M_READ : M_DONE;
        end
        M_READ: begin
          void'(rd_sched.pop_front());
          if (rd_sched.size() == 0) m_mode = M_DONE;
        end
        M_DONE: if (bus.out_ready) begin
          void'(exp_q.pop_front());
          m_mode = M_IDLE;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_mode == M_IDLE && !bus.flush));
      chk("out_valid", 32'(bus.out_valid), 32'(m_mode == M_DONE));
      if (m_mode == M_READ) begin
        chk("rf_addr", 32'(bus.rf_addr), 32'(rd_sched[0]));
        chk("rf_rd_en", 32'(bus.rf_rd_en), 32'(rd_sched[0] != 5'd0));
      end else begin
        chk("rf_rd_en_idle", 32'(bus.rf_rd_en), 32'd0);
      end
      if (m_mode == M_DONE && exp_q.size() != 0) begin
        chk("rd",      32'(bus.rd),  32'(exp_q[0][94:90]));
        chk("IS",      32'(bus.IS),  32'(exp_q[0][89:86]));
        chk("Imm",     32'(bus.Imm), 32'(exp_q[0][85:64]));
        chk("rs1_val", bus.rs1_val,  exp_q[0][63:32]);
        chk("R",       bus.R,        exp_q[0][31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  logic [31:0] got_rs1, got_r;
  logic [21:0] got_imm;
  logic [3:0]  got_is;
  logic [4:0]  got_rd;
  logic [4:0]  trace_q[$];
  int          got_lat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input int stall);
    logic acc;
    logic seen;
    trace_q.delete();
    bus.instr     = ins;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    acc = 1'b0;
    for (int g = 0; g < 20 && !acc; g++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
    end
    chk("accepted", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
    got_lat = 1;
    seen = 1'b0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (bus.rf_rd_en) trace_q.push_back(bus.rf_addr);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
      got_lat++;
    end
    chk("out_valid_seen", 32'(seen), 32'd1);
    got_rs1 = bus.rs1_val;
    got_r   = bus.R;
    got_imm = bus.Imm;
    got_is  = bus.IS;
    got_rd  = bus.rd;
    repeat (stall) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("handshake_done", 32'(bus.out_valid), 32'd0);
    tick();
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] table_instr [6];
  int          acc_cnt;
  logic        seen_valid;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 32; k++) rf_mem[k] = 32'h11 * k;
    rf_mem[0]     = 32'hDEADBEEF;
    bus.flush     = 1'b0;
    bus.instr     = 32'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_rf_rd_en",  32'(bus.rf_rd_en),  32'd0);
    chk("rst_rf_addr",   32'(bus.rf_addr),   32'd0);
    chk("rst_rs1_val",   bus.rs1_val,        32'd0);
    chk("rst_R",         bus.R,              32'd0);
    chk("rst_Imm",       32'(bus.Imm),       32'd0);
    chk("rst_IS",        32'(bus.IS),        32'd0);
    chk("rst_rd",        32'(bus.rd),        32'd0);
    tick();

    // add r3,r1,r2
    send(32'h86004002, 0);
    chk("add_lat",     32'(got_lat), 32'd3);
    chk("add_nreads",  32'(trace_q.size()), 32'd2);
    if (trace_q.size() == 2) begin
      chk("add_addr0", 32'(trace_q[0]), 32'd1);
      chk("add_addr1", 32'(trace_q[1]), 32'd2);
    end
    chk("add_rs1", got_rs1, 32'h11);
    chk("add_R",   got_r,   32'h22);
    chk("add_IS",  32'(got_is), 32'b1000);
    chk("add_rd",  32'(got_rd), 32'd3);

    // sethi 0x3FFFFF,r1
    send(32'h033FFFFF, 0);
    chk("sethi_lat",    32'(got_lat), 32'd1);
    chk("sethi_nreads", 32'(trace_q.size()), 32'd0);
    chk("sethi_IS",     32'(got_is), 32'b0000);
    chk("sethi_Imm",    32'(got_imm), 32'h3FFFFF);
    chk("sethi_rd",     32'(got_rd), 32'd1);

    // add r4,r0,-1
    send(32'h88003FFF, 0);
    chk("addi_lat",    32'(got_lat), 32'd2);
    chk("addi_nreads", 32'(trace_q.size()), 32'd0);
    chk("addi_rs1",    got_rs1, 32'd0);
    chk("addi_R",      got_r,   32'd0);
    chk("addi_IS",     32'(got_is), 32'b1010);
    chk("addi_Imm",    32'(got_imm), 32'h001FFF);

    // sll r5,r6,7 with a 5-cycle stall
    send(32'h8B29A007, 5);
    chk("sll_lat",  32'(got_lat), 32'd2);
    chk("sll_IS",   32'(got_is), 32'b1100);
    chk("sll_Imm",  32'(got_imm), 32'h000007);
    chk("sll_rs1",  got_rs1, 32'h66);
    chk("sll_rd",   32'(got_rd), 32'd5);

    // call, ba, or (reg), srl (reg), xor r0 imm, sra imm
    table_instr[0] = 32'h40000010;
    table_instr[1] = 32'h10800005;
    table_instr[2] = 32'h8E12400A;
    table_instr[3] = 32'h83308003;
    table_instr[4] = 32'h84182ABC;
    table_instr[5] = 32'h8B39A01F;
    for (int t = 0; t < 6; t++) send(table_instr[t], t % 3);
    table_instr[0] = 32'h10800005;
    send(table_instr[0], 0);
    chk("ba_IS",  32'(got_is), 32'b0010);
    chk("ba_Imm", 32'(got_imm), 32'h000005);

    // reset asserted during RS2
    bus.instr    = 32'h86004002;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rs2_rd_en", 32'(bus.rf_rd_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rf_rd_en",  32'(bus.rf_rd_en),  32'd0);
    chk("async_rf_addr",   32'(bus.rf_addr),   32'd0);
    chk("async_rs1_val",   bus.rs1_val,        32'd0);
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_in_ready",  32'(bus.in_ready),  32'd1);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // flush during RS1
    bus.instr    = 32'h86004002;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    tick();
    bus.flush  = 1'b0;
    seen_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    chk("flush_rs1_no_valid", 32'(seen_valid), 32'd0);
    tick();

    // flush with in_valid in IDLE blocks acceptance
    bus.instr    = 32'h033FFFFF;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(negedge clk);
    chk("flush_idle_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    chk("flush_idle_no_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_idle_ready",    32'(bus.in_ready),  32'd1);
    tick();

    // flush together with out_ready in DONE
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("flush_done_valid", 32'(bus.out_valid), 32'd0);
    tick();

    // throughput: zero-read instructions every 2 cycles
    bus.instr     = 32'h033FFFFF;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    acc_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.in_ready && bus.in_valid) acc_cnt++;
    end
    bus.in_valid = 1'b0;
    chk("throughput", 32'(acc_cnt), 32'd4);
    tick();
    bus.out_ready = 1'b0;
    repeat (2) tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
